// File: rtl/carry_skip_adder_unit.sv
// Registered carry-skip adder: BLOCK-bit ripple groups, each with a propagate-driven skip mux.
// Optional macro CSA_IN_REG_EN adds an input register stage (2-cycle latency instead of 1).
module carry_skip_adder_unit #(
    parameter int WIDTH = 4,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY,
    output logic             out_valid
);

    localparam int NGRP = WIDTH / BLOCK;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic             add_valid;

`ifdef CSA_IN_REG_EN
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic             in_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            in_valid_q <= 1'b0;
        end else begin
            a_q        <= A;
            b_q        <= B;
            cin_q      <= Cin;
            in_valid_q <= in_valid;
        end
    end

    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_cin   = cin_q;
    assign add_valid = in_valid_q;
`else
    assign add_a     = A;
    assign add_b     = B;
    assign add_cin   = Cin;
    assign add_valid = in_valid;
`endif

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] sum_d;
    logic             carry_d;

    assign p = add_a ^ add_b;
    assign g = add_a & add_b;

    // A fully-propagating group forwards its carry-in past the ripple chain.
    always_comb begin
        logic c;
        logic grp_cin;
        logic grp_p;
        sum_d   = '0;
        c       = 1'b0;
        grp_p   = 1'b0;
        grp_cin = add_cin;
        for (int gi = 0; gi < NGRP; gi++) begin
            c     = grp_cin;
            grp_p = 1'b1;
            for (int bi = 0; bi < BLOCK; bi++) begin
                sum_d[gi*BLOCK+bi] = p[gi*BLOCK+bi] ^ c;
                c                  = g[gi*BLOCK+bi] | (p[gi*BLOCK+bi] & c);
                grp_p              = grp_p & p[gi*BLOCK+bi];
            end
            grp_cin = grp_p ? grp_cin : c;
        end
        carry_d = grp_cin;
    end

    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= add_valid;
            if (add_valid) begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
        end
    end

    assign SUM       = sum_q;
    assign CARRY     = carry_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_carry_skip_adder_unit.sv
// Self-checking bench for carry_skip_adder_unit: a 4-bit and a 16-bit instance checked
// against directed vectors and an A+B+Cin arithmetic model; honours CSA_IN_REG_EN latency.
module tb_carry_skip_adder_unit;

`ifdef CSA_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;

    logic        v4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        c4;
    logic [3:0]  s4;
    logic        co4;
    logic        ov4;

    logic        v16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        c16;
    logic [15:0] s16;
    logic        co16;
    logic        ov16;

    int total;
    int bad;

    carry_skip_adder_unit #(.WIDTH(4), .BLOCK(4)) u4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (v4),
        .A        (a4),
        .B        (b4),
        .Cin      (c4),
        .SUM      (s4),
        .CARRY    (co4),
        .out_valid(ov4)
    );

    carry_skip_adder_unit #(.WIDTH(16), .BLOCK(4)) u16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (v16),
        .A        (a16),
        .B        (b16),
        .Cin      (c16),
        .SUM      (s16),
        .CARRY    (co16),
        .out_valid(ov16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       carry;
    } vec4_t;

    // Drives one valid 4-bit add and waits until its result is visible.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic cin);
        @(negedge clk);
        a4 = a;
        b4 = b;
        c4 = cin;
        v4 = 1'b1;
        repeat (LAT) begin
            @(negedge clk);
            v4 = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a4  = 4'($urandom);
        b4  = 4'($urandom);
        c4  = 1'($urandom);
        v4  = 1'b1;
        a16 = 16'($urandom);
        b16 = 16'($urandom);
        c16 = 1'($urandom);
        v16 = 1'b1;
        #2;
        total++;
        if (s4 !== 4'h0 || co4 !== 1'b0 || ov4 !== 1'b0) begin
            bad++;
            $display("FAIL reset4 got sum=%h carry=%b valid=%b expected 0 0 0", s4, co4, ov4);
        end
        total++;
        if (s16 !== 16'h0 || co16 !== 1'b0 || ov16 !== 1'b0) begin
            bad++;
            $display("FAIL reset16 got sum=%h carry=%b valid=%b expected 0 0 0", s16, co16, ov16);
        end
        @(negedge clk);
        v4    = 1'b0;
        v16   = 1'b0;
        rst_n = 1'b1;
        applyStimulus(4'b1010, 4'b0100, 1'b1);
        total++;
        if (s4 !== 4'b1111 || co4 !== 1'b0 || ov4 !== 1'b1) begin
            bad++;
            $display("FAIL first_after_reset got sum=%b carry=%b valid=%b expected 1111 0 1", s4, co4, ov4);
        end
    endtask

    task automatic test_directed();
        vec4_t tbl[7];
        tbl[0] = '{4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b1};
        tbl[1] = '{4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0};
        tbl[2] = '{4'b1010, 4'b1101, 1'b0, 4'b0111, 1'b1};
        tbl[3] = '{4'b1010, 4'b1111, 1'b0, 4'b1001, 1'b1};
        tbl[4] = '{4'b1110, 4'b0100, 1'b1, 4'b0011, 1'b1};
        tbl[5] = '{4'b1000, 4'b1101, 1'b0, 4'b0101, 1'b1};
        tbl[6] = '{4'b0010, 4'b1111, 1'b0, 4'b0001, 1'b1};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(tbl[i].a, tbl[i].b, tbl[i].cin);
            total++;
            if (s4 !== tbl[i].sum || co4 !== tbl[i].carry || ov4 !== 1'b1) begin
                bad++;
                $display("FAIL directed[%0d] got sum=%b carry=%b valid=%b expected %b %b 1",
                         i, s4, co4, ov4, tbl[i].sum, tbl[i].carry);
            end
        end
    endtask

    task automatic test_hold();
        applyStimulus(4'b1011, 4'b0101, 1'b1);
        total++;
        if (s4 !== 4'b0001 || co4 !== 1'b1 || ov4 !== 1'b1) begin
            bad++;
            $display("FAIL hold_load got sum=%b carry=%b valid=%b expected 0001 1 1", s4, co4, ov4);
        end
        for (int i = 0; i < 3; i++) begin
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            c4 = 1'($urandom);
            @(negedge clk);
            total++;
            if (s4 !== 4'b0001 || co4 !== 1'b1 || ov4 !== 1'b0) begin
                bad++;
                $display("FAIL hold[%0d] got sum=%b carry=%b valid=%b expected 0001 1 0", i, s4, co4, ov4);
            end
        end
    endtask

    task automatic test_exhaustive4();
        logic [4:0] q[$];
        logic [4:0] expv;
        for (int k = 0; k < 512 + LAT; k++) begin
            @(negedge clk);
            if (k >= LAT) begin
                expv = q.pop_front();
                total++;
                if ({co4, s4} !== expv || ov4 !== 1'b1) begin
                    bad++;
                    $display("FAIL exhaustive4[%0d] got carry=%b sum=%b valid=%b expected %b %b 1",
                             k - LAT, co4, s4, ov4, expv[4], expv[3:0]);
                end
            end
            if (k < 512) begin
                {a4, b4, c4} = 9'(k);
                v4 = 1'b1;
                q.push_back(5'({1'b0, a4}) + 5'({1'b0, b4}) + 5'(c4));
            end else begin
                v4 = 1'b0;
            end
        end
    endtask

    task automatic test_stream16();
        logic [16:0] q[$];
        logic [16:0] expv;
        for (int k = 0; k < 8 + LAT; k++) begin
            @(negedge clk);
            if (k >= LAT) begin
                expv = q.pop_front();
                total++;
                if ({co16, s16} !== expv || ov16 !== 1'b1) begin
                    bad++;
                    $display("FAIL stream16[%0d] got carry=%b sum=%h valid=%b expected %b %h 1",
                             k - LAT, co16, s16, ov16, expv[16], expv[15:0]);
                end
            end
            if (k < 8) begin
                a16 = 16'($urandom);
                b16 = 16'($urandom);
                c16 = 1'($urandom);
                v16 = 1'b1;
                q.push_back(17'({1'b0, a16}) + 17'({1'b0, b16}) + 17'(c16));
            end else begin
                v16 = 1'b0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a16 = 16'($urandom) | 16'h8000;
            b16 = 16'($urandom) | 16'h8000;
            c16 = 1'b1;
            v16 = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (s16 !== 16'h0 || co16 !== 1'b0 || ov16 !== 1'b0) begin
            bad++;
            $display("FAIL midreset got sum=%h carry=%b valid=%b expected 0 0 0", s16, co16, ov16);
        end
        v16 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (s16 !== 16'h0 || co16 !== 1'b0 || ov16 !== 1'b0) begin
            bad++;
            $display("FAIL after_midreset got sum=%h carry=%b valid=%b expected 0 0 0", s16, co16, ov16);
        end
    endtask

    task automatic test_sweep16();
        logic [16:0] q[$];
        logic [16:0] expv;
        logic [15:0] va[44];
        logic [15:0] vb[44];
        logic        vc[44];
        va[0] = 16'hFFFF; vb[0] = 16'h0000; vc[0] = 1'b1;
        va[1] = 16'hFFFF; vb[1] = 16'hFFFF; vc[1] = 1'b1;
        va[2] = 16'h0000; vb[2] = 16'h0000; vc[2] = 1'b0;
        va[3] = 16'hAAAA; vb[3] = 16'h5555; vc[3] = 1'b1;
        for (int i = 4; i < 44; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 16'($urandom);
            vc[i] = 1'($urandom);
        end
        for (int k = 0; k < 44 + LAT; k++) begin
            @(negedge clk);
            if (k >= LAT) begin
                expv = q.pop_front();
                total++;
                if ({co16, s16} !== expv || ov16 !== 1'b1) begin
                    bad++;
                    $display("FAIL sweep16[%0d] got carry=%b sum=%h valid=%b expected %b %h 1",
                             k - LAT, co16, s16, ov16, expv[16], expv[15:0]);
                end
            end
            if (k < 44) begin
                a16 = va[k];
                b16 = vb[k];
                c16 = vc[k];
                v16 = 1'b1;
                q.push_back(17'({1'b0, a16}) + 17'({1'b0, b16}) + 17'(c16));
            end else begin
                v16 = 1'b0;
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_hold();
        test_exhaustive4();
        test_stream16();
        test_sweep16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
